// File: rtl/tdc_pkg.sv
// tdc_pkg: shared FSM states, default sizing and helpers for the TDC blocks
package tdc_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, COUNT, HOLD} state_t;

    localparam int W_DEF       = 8;
    localparam int TIMEOUT_DEF = 511;

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max);
        return (cnt >= max) ? max : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/tdc_edge_det.sv
// tdc_edge_det: registers a synchronous level and flags its rising and falling edges
module tdc_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= 1'b0;
        else      q <= d;
    end

    assign rise = d & ~q;
    assign fall = ~d & q;

endmodule

// File: rtl/tdc_wsign.sv
// tdc_wsign: pulse-width TDC with sign capture and valid/ready result
// Define TDC_SIGNED_OUT_EN for a two's-complement dout clamped at 2^(W-1)-1.
module tdc_wsign
    import tdc_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         trig,
    input  logic         pulse_in,
    input  logic         sign_in,
    output logic [W-1:0] dout,
    output logic         dout_sign,
    output logic         dout_sat,
    output logic         dout_tmo,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
`ifdef TDC_SIGNED_OUT_EN
    localparam logic [W-1:0] CMAX = {1'b0, {(W-1){1'b1}}};
`else
    localparam logic [W-1:0] CMAX = '1;
`endif

    state_t state, nxt;
    logic [W-1:0] cnt, code;
    logic [TW-1:0] tmo_cnt;
    logic rise, fall;

    tdc_edge_det u_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (pulse_in),
        .rise (rise),
        .fall (fall)
    );

`ifdef TDC_SIGNED_OUT_EN
    assign code = dout_sign ? -cnt : cnt;
`else
    assign code = cnt;
`endif

    assign busy = state != IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    // In COUNT the previous sample was always high, so fall is just pulse_in low.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = trig ? ARMED : IDLE;
            ARMED:   nxt = rise ? COUNT : (tmo_cnt == TMO_LAST) ? HOLD : ARMED;
            COUNT:   nxt = fall ? HOLD : COUNT;
            default: nxt = dout_ready ? IDLE : HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            tmo_cnt    <= '0;
            dout       <= '0;
            dout_sign  <= 1'b0;
            dout_sat   <= 1'b0;
            dout_tmo   <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (trig) begin
                    cnt       <= '0;
                    tmo_cnt   <= '0;
                    dout_sign <= 1'b0;
                    dout_sat  <= 1'b0;
                    dout_tmo  <= 1'b0;
                end
                ARMED: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (rise) begin
                        cnt       <= W'(1);
                        dout_sign <= sign_in;
                    end else if (tmo_cnt == TMO_LAST) begin
                        dout       <= '0;
                        dout_tmo   <= 1'b1;
                        dout_valid <= 1'b1;
                    end
                end
                COUNT: begin
                    if (fall) begin
                        dout       <= code;
                        dout_sat   <= cnt == CMAX;
                        dout_valid <= 1'b1;
                    end else begin
                        cnt <= W'(sat_inc(32'(cnt), 32'(CMAX)));
                    end
                end
                default: if (dout_ready) dout_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_wsign.sv
// tb_tdc_wsign: directed stimulus with a queue scoreboard checked on each handshake
module tb_tdc_wsign;

    logic clk = 0, rst = 1, trig = 0, pulse_in = 0, sign_in = 0, dout_ready = 1;
    logic [7:0] dout;
    logic dout_sign, dout_sat, dout_tmo, dout_valid, busy;
    int pass_n = 0, total_n = 0;

    typedef struct packed {
        logic [7:0] d;
        logic s;
        logic sat;
        logic tmo;
    } exp_t;
    exp_t q[$];

    tdc_wsign dut (
        .clk        (clk),
        .rst        (rst),
        .trig       (trig),
        .pulse_in   (pulse_in),
        .sign_in    (sign_in),
        .dout       (dout),
        .dout_sign  (dout_sign),
        .dout_sat   (dout_sat),
        .dout_tmo   (dout_tmo),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic exp_t model(input int n, input logic s, input logic tmo);
        exp_t e;
`ifdef TDC_SIGNED_OUT_EN
        int m = (n >= 127) ? 127 : n;
        e.sat = n >= 127;
        e.d = s ? 8'(-m) : 8'(m);
`else
        e.sat = n >= 255;
        e.d = (n >= 255) ? 8'd255 : 8'(n);
`endif
        if (tmo) begin
            e.d = 8'd0;
            e.sat = 1'b0;
        end
        e.s = s;
        e.tmo = tmo;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst && dout_valid && dout_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result{dout,sign,sat,tmo}", {21'd0, dout, dout_sign, dout_sat, dout_tmo}, {21'd0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fire();
        trig = 1;
        tick();
        trig = 0;
    endtask

    task automatic pulse(input int n, input logic s);
        sign_in = s;
        pulse_in = 1;
        repeat (n) tick();
        pulse_in = 0;
    endtask

    initial begin
        #1 rst = 0;
        #1;
        chk("rst_outputs", {dout, dout_sign, dout_sat, dout_tmo, dout_valid, busy}, '0);
        @(posedge clk);
        #1 rst = 1;
        tick();
        chk("idle_busy", busy, 0);

        // basic: 37-cycle pulse, sign 1
        fire();
        repeat (3) tick();
        chk("armed_busy", busy, 1);
        q.push_back(model(37, 1, 0));
        pulse(37, 1);
        chk("valid_before_fall_sample", dout_valid, 0);
        tick();
        chk("valid_after_fall", dout_valid, 1);
        tick();

        // saturation
        fire();
        tick();
        q.push_back(model(300, 1, 0));
        pulse(300, 1);
        repeat (2) tick();

        // asynchronous reset mid-COUNT
        fire();
        tick();
        sign_in = 1;
        pulse_in = 1;
        repeat (10) tick();
        #2 rst = 0;
        #1;
        chk("async_rst_outputs", {dout, dout_sign, dout_sat, dout_tmo, dout_valid, busy}, '0);
        pulse_in = 0;
        tick();
        rst = 1;
        repeat (3) tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_valid", dout_valid, 0);

        // timeout
        fire();
        q.push_back(model(0, 0, 1));
        repeat (510) tick();
        chk("tmo_not_yet", dout_valid, 0);
        tick();
        chk("tmo_valid", dout_valid, 1);
        tick();

        // backpressure with a second trig and pulse during HOLD
        dout_ready = 0;
        fire();
        tick();
        q.push_back(model(10, 0, 0));
        pulse(10, 0);
        tick();
        chk("bp_valid", dout_valid, 1);
        repeat (2) tick();
        fire();
        pulse(5, 1);
        repeat (10) tick();
        chk("bp_busy", busy, 1);
        chk("bp_hold_value", {dout, dout_sign, dout_valid}, {8'd10, 1'b0, 1'b1});
        dout_ready = 1;
        tick();
        repeat (3) tick();
        chk("bp_release_busy", busy, 0);

        // stale-high pulse before trig
        pulse_in = 1;
        repeat (3) tick();
        fire();
        repeat (5) tick();
        chk("stale_no_capture", {busy, dout_valid}, {1'b1, 1'b0});
        pulse_in = 0;
        repeat (2) tick();
        q.push_back(model(5, 0, 0));
        pulse(5, 0);
        repeat (2) tick();
        chk("stale_done_busy", busy, 0);

        repeat (5) tick();
        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
